// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode target-address path.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_IMM_W  = 16;
    localparam int DEF_JMP_W  = 26;
    localparam int DEF_SHIFT  = 2;

    // Target-generation modes; 2'b11 is an alias of offset-only.
    typedef enum logic [1:0] {
        MODE_REL     = 2'b00,
        MODE_JMP     = 2'b01,
        MODE_OFF     = 2'b10,
        MODE_OFF_ALT = 2'b11
    } mode_e;

    // Fold the alias encoding onto MODE_OFF so downstream logic sees three modes.
    function automatic mode_e norm_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'b00:   r = MODE_REL;
            2'b01:   r = MODE_JMP;
            default: r = MODE_OFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_extend_shift.sv
// Extends an immediate (sign from IMM_W bits or zero from JMP_W bits) to ADDR_W, then shifts left.
// Latency: purely combinational.
// Backpressure: none; no state.
module imm_extend_shift #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16,
    parameter int JMP_W  = 26,
    parameter int SHIFT  = 2
) (
    input  logic [JMP_W-1:0]  imm_i,
    input  logic              sext_i,
    output logic [ADDR_W-1:0] off_o
);

    logic [IMM_W-1:0]  imm_lo;
    logic [ADDR_W-1:0] ext;

    assign imm_lo = imm_i[IMM_W-1:0];

    // Branch immediates use only the low IMM_W bits and carry their sign;
    // jump indices use the full JMP_W field as an unsigned value.
    always_comb begin
        ext = '0;
        if (sext_i) begin
            ext = ADDR_W'($signed(imm_lo));
        end else begin
            ext = ADDR_W'(imm_i);
        end
    end

    assign off_o = ext << SHIFT;

endmodule

// File: rtl/branch_target_unit.sv
// Two-stage branch/jump target generator: extend+shift in stage 1, add/concat in stage 2.
// Latency: result valid 2 cycles after the input is presented (1 register per stage), 1 result/cycle.
// Backpressure: combinational in_ready from out_ready, no skid buffer; flush squashes both stages.
import mips_pkg::*;

module branch_target_unit #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter int JMP_W  = DEF_JMP_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [JMP_W-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_target,
    output logic              out_wrap,
    output logic [1:0]        out_mode
);

    // Bits of the target supplied by the jump index; the rest come from the PC.
    localparam logic [ADDR_W-1:0] JMP_MASK =
        (JMP_W + SHIFT >= ADDR_W) ? {ADDR_W{1'b1}}
                                  : ((ADDR_W'(1) << (JMP_W + SHIFT)) - ADDR_W'(1));

    // Stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_pc_q;
    logic [ADDR_W-1:0] s1_off_q;
    mode_e             s1_mode_q;

    // Stage 2 / output state
    logic              s2_valid_q, s2_valid_d;
    logic [ADDR_W-1:0] out_target_q, out_target_d;
    logic              out_wrap_q, out_wrap_d;
    logic [1:0]        out_mode_q;

    // Handshake and stage-1 datapath
    logic              s2_adv;
    logic              s1_adv;
    logic              accept;
    mode_e             in_mode_n;
    logic              sext_sel;
    logic [ADDR_W-1:0] ext_off;
    logic [ADDR_W:0]   rel_sum;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;

    assign in_mode_n = norm_mode(in_mode);
    assign sext_sel  = (in_mode_n != MODE_JMP);

    imm_extend_shift #(
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W),
        .JMP_W  (JMP_W),
        .SHIFT  (SHIFT)
    ) u_ext (
        .imm_i  (in_imm),
        .sext_i (sext_sel),
        .off_o  (ext_off)
    );

    // Stage-1 occupancy: flush wins over a same-cycle accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage-2 occupancy: refilled from stage 1 whenever it may advance.
    always_comb begin
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
    end

    // Stage-2 compute: the 1-bit-wider sum exposes the carry used for wrap detection.
    assign rel_sum = {1'b0, s1_pc_q} + {1'b0, s1_off_q};

    // Target select; a negative offset wraps when it fails to borrow back (no carry).
    always_comb begin
        out_target_d = s1_off_q;
        out_wrap_d   = 1'b0;
        case (s1_mode_q)
            MODE_REL: begin
                out_target_d = rel_sum[ADDR_W-1:0];
                out_wrap_d   = s1_off_q[ADDR_W-1] ? !rel_sum[ADDR_W] : rel_sum[ADDR_W];
            end
            MODE_JMP: begin
                out_target_d = (s1_pc_q & ~JMP_MASK) | (s1_off_q & JMP_MASK);
            end
            default: begin
                out_target_d = s1_off_q;
            end
        endcase
    end

    // Valid bits: reset asynchronously, everything in flight is discarded.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage-1 payload: only captured on accept, so it needs no reset.
    always_ff @(posedge Clk) begin
        if (accept) begin
            s1_pc_q   <= in_pc;
            s1_off_q  <= ext_off;
            s1_mode_q <= in_mode_n;
        end
    end

    // Output payload: held while stalled, loaded only when stage 1 moves forward.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_target_q <= '0;
            out_wrap_q   <= 1'b0;
            out_mode_q   <= 2'b00;
        end else if (s1_adv) begin
            out_target_q <= out_target_d;
            out_wrap_q   <= out_wrap_d;
            out_mode_q   <= s1_mode_q;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_target = out_target_q;
    assign out_wrap   = out_wrap_q;
    assign out_mode   = out_mode_q;

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit: directed cases, backpressure, flush, reset, random traffic.
// Expected results come from a plain-arithmetic model pushed on accept and popped on output handshake.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_branch_target_unit;

    localparam longint SPACE = 64'sh1_0000_0000;

    typedef struct {
        logic [31:0] target;
        logic        wrap;
        logic [1:0]  mode;
    } exp_t;

    logic        Clk;
    logic        Rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [31:0] in_pc;
    logic [25:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_target;
    logic        out_wrap;
    logic [1:0]  out_mode;

    int vectors    = 0;
    int miscompares = 0;

    exp_t exp_q[$];

    logic        have_prev = 1'b0;
    logic [31:0] prev_target;
    logic        prev_wrap;
    logic [1:0]  prev_mode;

    branch_target_unit dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_pc      (in_pc),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_target (out_target),
        .out_wrap   (out_wrap),
        .out_mode   (out_mode)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: real-number address arithmetic, wrap = result outside [0, 2^32).
    function automatic exp_t model(input logic [1:0] m, input logic [31:0] pc, input logic [25:0] imm);
        exp_t        e;
        logic [15:0] lo;
        longint      simm;
        longint      t;
        lo     = imm[15:0];
        simm   = lo[15] ? (longint'(lo) - 65536) : longint'(lo);
        e.mode = (m == 2'b11) ? 2'b10 : m;
        e.wrap = 1'b0;
        t      = 0;
        case (e.mode)
            2'b00: begin
                t      = longint'(pc) + simm * 4;
                e.wrap = (t < 0) || (t >= SPACE);
            end
            2'b01: t = (longint'(pc) / 268435456) * 268435456 + longint'(imm) * 4;
            default: t = simm * 4;
        endcase
        e.target = t[31:0];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pushes on accept, pops/compares on output handshake, checks stall stability.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            exp_q.delete();
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                vectors++;
                if (out_valid !== 1'b1 || out_target !== prev_target ||
                    out_wrap !== prev_wrap || out_mode !== prev_mode) begin
                    miscompares++;
                    $display("FAIL stall_stable: got v=%b t=%h w=%b m=%b expected v=1 t=%h w=%b m=%b",
                             out_valid, out_target, out_wrap, out_mode, prev_target, prev_wrap, prev_mode);
                end
            end
            have_prev = 1'b0;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_output: got t=%h with no entry outstanding, expected none", out_target);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (out_target !== e.target || out_wrap !== e.wrap || out_mode !== e.mode) begin
                            miscompares++;
                            $display("FAIL result: got t=%h w=%b m=%b expected t=%h w=%b m=%b",
                                     out_target, out_wrap, out_mode, e.target, e.wrap, e.mode);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(in_mode, in_pc, in_imm));
                end
                if (out_valid && !out_ready) begin
                    have_prev   = 1'b1;
                    prev_target = out_target;
                    prev_wrap   = out_wrap;
                    prev_mode   = out_mode;
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    // Single transfer on an empty pipe with constant expected values and latency check.
    task automatic directed(input string nm, input logic [1:0] m, input logic [31:0] pc,
                            input logic [25:0] imm, input logic [31:0] et, input logic ew,
                            input logic [1:0] em);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = m;
        in_pc     = pc;
        in_imm    = imm;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_accept"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk({nm, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({nm, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_target"}, out_target, et);
        chk({nm, "_wrap"}, {31'd0, out_wrap}, {31'd0, ew});
        chk({nm, "_mode"}, {30'd0, out_mode}, {30'd0, em});
        tick();
    endtask

    initial begin
        logic [31:0] bp_pc [4];
        logic [25:0] bp_imm[4];
        int acc;
        int n;
        logic was_rdy;

        flush     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_pc     = '0;
        in_imm    = '0;
        out_ready = 1'b1;
        Rst_n     = 1'b0;

        #2;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_target", out_target, 32'd0);
        chk("reset_out_wrap", {31'd0, out_wrap}, 32'd0);
        chk("reset_out_mode", {30'd0, out_mode}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        Rst_n = 1'b1;
        tick();

        // Relative, wrap cases, jump, offset, alias mode, ignored upper immediate bits.
        directed("rel_back", 2'b00, 32'h0040_0004, 26'h000_FFFF, 32'h0040_0000, 1'b0, 2'b00);
        directed("rel_wrap_neg", 2'b00, 32'h0000_0004, 26'h000_8000, 32'hFFFE_0004, 1'b1, 2'b00);
        directed("rel_wrap_pos", 2'b00, 32'hFFFF_FFFC, 26'h000_0001, 32'h0000_0000, 1'b1, 2'b00);
        directed("jump", 2'b01, 32'h9000_0004, 26'h010_0000, 32'h9040_0000, 1'b0, 2'b01);
        directed("offset", 2'b10, 32'h1234_5678, 26'h000_0010, 32'h0000_0040, 1'b0, 2'b10);
        directed("offset_alias", 2'b11, 32'h1234_5678, 26'h000_0010, 32'h0000_0040, 1'b0, 2'b10);
        directed("offset_upper_ignored", 2'b10, 32'h0, 26'h3FF_0010, 32'h0000_0040, 1'b0, 2'b10);
        directed("rel_upper_ignored", 2'b00, 32'h0000_1000, 26'h3FF_0004, 32'h0000_1010, 1'b0, 2'b00);

        // Backpressure: four back-to-back inputs with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            bp_pc[i]  = 32'h0010_0000 + 32'(i) * 32'h100;
            bp_imm[i] = 26'(16'h0010 + 16'(i));
        end
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_pc     = bp_pc[0];
        in_imm    = bp_imm[0];
        for (int c = 0; c < 5; c++) begin
            was_rdy = in_ready;
            tick();
            if (was_rdy) begin
                acc++;
                if (acc < 4) begin
                    in_pc  = bp_pc[acc];
                    in_imm = bp_imm[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("bp_accepted_while_stalled", 32'(acc), 32'd2);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        n = 0;
        while (acc < 4 && n < 20) begin
            was_rdy = in_ready;
            tick();
            n++;
            if (was_rdy) begin
                acc++;
                if (acc < 4) begin
                    in_pc  = bp_pc[acc];
                    in_imm = bp_imm[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("bp_all_accepted", 32'(acc), 32'd4);
        drain(5);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Flush with one entry in each stage and a simultaneous accept.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_pc     = 32'h0000_0100;
        in_imm    = 26'h1;
        tick();
        in_pc     = 32'h0000_0200;
        tick();
        chk("flush_pre_in_ready", {31'd0, in_ready}, 32'd0);
        in_pc     = 32'h0000_0300;
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("flush_in_ready_normal", {31'd0, in_ready}, 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid_next", {31'd0, out_valid}, 32'd0);
        tick();
        chk("flush_no_late_result", {31'd0, out_valid}, 32'd0);
        directed("post_flush", 2'b00, 32'h0000_0400, 26'h000_0002, 32'h0000_0408, 1'b0, 2'b00);

        // Randomized traffic with random stalls and occasional flushes.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       in_pc = 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
                1:       in_pc = 32'($urandom_range(0, 65535));
                default: in_pc = $urandom;
            endcase
            in_imm    = 26'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            tick();
        end
        drain(10);
        chk("random_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a result is being held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_pc     = 32'h0000_1000;
        in_imm    = 26'h0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("arst_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("arst_pre_target", out_target, 32'h0000_1000);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_target", out_target, 32'd0);
        chk("arst_out_wrap", {31'd0, out_wrap}, 32'd0);
        chk("arst_out_mode", {30'd0, out_mode}, 32'd0);
        tick();
        tick();
        Rst_n = 1'b1;
        #1;
        chk("arst_release_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        directed("post_reset", 2'b01, 32'hA000_0000, 26'h000_0003, 32'hA000_000C, 1'b0, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
- Parametrised successor to the fixed 11-bit sign-extend/shift-by-2 offset block.
- Two-stage pipelined target-address generator for the MIPS fetch/decode path.
- Sign- or zero-extends an immediate, shifts it, then either adds it to PC+4 (relative branch) or concatenates it with PC upper bits (jump).
- valid/ready handshake on both sides; flush support for mispredict/exception squash.

Parameters:
ADDR_W, 32, address/PC width
IMM_W, 16, branch immediate width (sign-extended); IMM_W <= JMP_W
JMP_W, 26, jump index width (zero-extended); JMP_W+SHIFT <= ADDR_W
SHIFT, 2, left-shift amount applied to immediate

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all in-flight entries
in_valid  in  1  input request valid
in_ready  out  1  unit can accept input this cycle
in_mode  in  2  00 rel branch, 01 jump, 10 offset-only, 11 treated as 10
in_pc  in  ADDR_W  PC+4 of the branch/jump
in_imm  in  JMP_W  immediate; rel/offset modes use in_imm[IMM_W-1:0]
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_target  out  ADDR_W  computed target
out_wrap  out  1  relative add wrapped past address space
out_mode  out  2  mode carried with result (11 reported as 10)

Behaviour:
- Reset (Rst_n low, async): s1_valid=0, s2_valid=0, out_valid=0, out_target=0, out_wrap=0, out_mode=0. Data regs need no reset apart from the outputs. Takes effect mid-transfer with no completion.
- Stage 1 (accept): on in_valid&&in_ready, registers pc, mode, and the extended, shifted offset.
  - rel/offset: off = sext(imm[IMM_W-1:0]) << SHIFT, ADDR_W bits.
  - jump: off = zext(imm[JMP_W-1:0]) << SHIFT.
- Stage 2 (compute), registered into the output:
  - rel: target = (pc + off) mod 2^ADDR_W. out_wrap=1 if offset non-negative with carry-out, or negative with no carry-out.
  - jump: target = {pc[ADDR_W-1:JMP_W+SHIFT], off[JMP_W+SHIFT-1:0]}, wrap=0.
  - offset: target = off, wrap=0.
- Handshake:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid && s2 advances.
  - in_ready = !s1_valid || s1 advances. Combinational backpressure only; no skid buffer.
  - Latency 2 cycles from accept to out_valid with out_ready held high. Throughput 1/cycle.
  - Outputs stay stable while out_valid && !out_ready.
- Flush: next edge clears s1_valid and s2_valid.
  - Flush beats a simultaneous accept: the input is dropped, and in_ready still reads its normal value.
  - Flush beats a simultaneous output handshake: the consumer must ignore a result presented in a flush cycle.
- Order is always preserved; no entry is lost or duplicated under any out_ready pattern.
- Upper in_imm bits above IMM_W are ignored in rel/offset modes.

Decomposition:
- Shared package (mips_pkg): mode encodings (MODE_REL, MODE_JMP, MODE_OFF), default widths.
- Sub-module imm_extend_shift: combinational extend+shift parametrised by IMM_W/JMP_W/SHIFT/ADDR_W with a sign/zero select. Instantiated in stage 1; replaces the old fixed block.

Test Plan:
- rel: pc=0x00400004, imm=0xFFFF, out_ready=1 -> 2 cycles later out_target=0x00400000, out_wrap=0.
- rel wrap: pc=0x00000004, imm=0x8000 -> out_target=0xFFFE0004, out_wrap=1. Also pc=0xFFFFFFFC, imm=0x0001 -> 0x00000000, out_wrap=1.
- jump/offset: pc=0x90000004, mode=01, imm=0x0100000 -> 0x90400000. mode=10, imm=0x0010 -> 0x00000040. mode=11 gives the same result with out_mode=10.
- backpressure: 4 back-to-back rel inputs with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted. On release, all 4 emerge in order with no loss or duplication; outputs stable while stalled.
- flush: flush=1 in the same cycle as an accept, with one entry in each stage -> out_valid=0 next cycle, no result emitted. The next accept after flush yields a correct result 2 cycles later.
- reset: Rst_n pulled low asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_target=0 immediately, before the next edge. After release, in_ready=1.
